sync_window_fifo_n_m: RTL and testbench
=======================================

// Module: sync_window_fifo_n_m
// PURPOSE
//  Single-clock, parametrised successor of the team's shift-register buffer.
//  - Show-ahead FIFO of 2**ADDRESS words, N bits wide, with valid/ready handshakes on both sides.
//  - Full, empty, almost-full and almost-empty flags, plus an occupancy count.
//  - M-word parallel window of the most recently written words; the window can be frozen for snapshot capture.
//  - Sits between a sample producer and a consumer that needs both stream access and a parallel block view.
// PARAMETERS
//  n        32   data word width (bits)
//  address  4    pointer width; DEPTH = 2**address words
//  m        16   window length in words; 1 <= m <= DEPTH
//  AFULL    12   fl_afull asserts when level_o >= AFULL
//  AEMPTY   2    fl_aempty asserts when level_o <= AEMPTY
// PORTS
//  clk_i       in   1            single clock; all logic on its rising edge
//  rst_i       in   1            synchronous reset, active-high
//  wr_i        in   n            write data
//  wr_valid_i  in   1            write request
//  wr_ready_o  out  1            write can be accepted (= ~fl_full)
//  rd_data_o   out  n            head-of-FIFO word (show-ahead)
//  rd_valid_o  out  1            rd_data_o is valid (= ~fl_empty)
//  rd_ready_i  in   1            consumer pops the head
//  flush_i     in   1            synchronous clear of FIFO and window
//  freeze_i    in   1            hold the window contents
//  data_o      out  n x [0:m-1]  window; data_o[m-1] is the newest word
//  win_valid_o out  1            m words have been written since reset/flush
//  level_o     out  address+1    words stored, 0..DEPTH
//  fl_full     out  1            level_o == DEPTH
//  fl_empty    out  1            level_o == 0
//  fl_afull    out  1            level_o >= AFULL
//  fl_aempty   out  1            level_o <= AEMPTY
//  ovf_o       out  1            sticky: write attempted while full
// BEHAVIOUR
//  Reset (rst_i=1 at edge) forces these values; all outputs are registered or decode registered state:
//  - pointers, level_o, data_o[*], win_valid_o, ovf_o and rd_data_o: 0
//  - fl_empty=1, fl_aempty=1, wr_ready_o=1, fl_full=0, fl_afull=0, rd_valid_o=0
//  Write accept: wr_valid_i & wr_ready_o.
//  - mem[wp] <= wr_i; wp increments and wraps DEPTH-1 -> 0.
//  Read accept: rd_ready_i & rd_valid_o.
//  - rp increments and wraps; a pop while empty is ignored.
//  Pointers: address+1 bits; the extra MSB distinguishes full from empty.
//  Level update (registered):
//  - write only: +1
//  - read only: -1
//  - both, or neither: unchanged
//  Flags are derived from the next level, so they are valid in the cycle after the accept.
//  Latency: a word written into an empty FIFO appears on rd_data_o one cycle later, with rd_valid_o=1.
//  Simultaneous cases:
//  - Full + rd + wr: the read is accepted; the write is refused (wr_ready_o=0) and ovf_o is set.
//  - Empty + rd + wr: the write is accepted and the read is ignored.
//  Occupancy state (decoded from level_o): EMPTY -> PARTIAL -> FULL.
//  - Moves only by +/-1 per cycle; there is no direct EMPTY <-> FULL jump, except DEPTH==1.
//  Window:
//  - On each accepted write with freeze_i=0: data_o[0:m-2] <= data_o[1:m-1], data_o[m-1] <= wr_i.
//  - freeze_i=1: the window holds, and FIFO writes continue.
//  - Releasing freeze_i does not backfill the window with words missed while frozen.
//  win_valid_o: a saturating counter of accepted writes while unfrozen; asserts when the count reaches m.
//  flush_i (priority below rst_i, above all traffic):
//  - Next cycle, FIFO state, window, counter and flags take their reset values.
//  - Writes and reads in the flush cycle are discarded.
//  - ovf_o is NOT cleared by flush; only rst_i clears it.
//  Reset or flush mid-burst: no partial word survives, and the first accepted write after it is read first.
// TESTING
//  1. Reset, then write 0x11,0x22,0x33 -> rd_data_o=0x11 one cycle after the first write; level_o=3; fl_empty=0.
//  2. Write 16 words (address=4) -> fl_full=1, wr_ready_o=0; a 17th write sets ovf_o=1 and 0x..10 is not stored.
//  3. Full FIFO, rd_ready_i=wr_valid_i=1 for one cycle -> level_o=15, the head pops, the write is refused.
//  4. Write 20 words 1..20, m=16 -> data_o[0]=5, data_o[15]=20, win_valid_o=1 from the 16th write.
//  5. freeze_i=1, then 3 writes -> data_o unchanged, level_o +3; after release the next write shifts in.
//  6. flush_i with level_o=7 -> next cycle level_o=0, fl_empty=1, win_valid_o=0, ovf_o keeps its value.

Source files
------------

// File: rtl/sync_window_fifo_n_m_if.sv
// Handshake and status bundle for sync_window_fifo_n_m.
// The slave modport is the FIFO side. The master modport is the producer/consumer side.
interface sync_window_fifo_n_m_if #(
  parameter int N       = 32,
  parameter int ADDRESS = 4,
  parameter int M       = 16
);
  logic [N-1:0]          wr_i;
  logic                  wr_valid_i;
  logic                  wr_ready_o;
  logic [N-1:0]          rd_data_o;
  logic                  rd_valid_o;
  logic                  rd_ready_i;
  logic                  flush_i;
  logic                  freeze_i;
  logic [M-1:0][N-1:0]   data_o;
  logic                  win_valid_o;
  logic [ADDRESS:0]      level_o;
  logic                  fl_full;
  logic                  fl_empty;
  logic                  fl_afull;
  logic                  fl_aempty;
  logic                  ovf_o;

  modport slave (
    input  wr_i, wr_valid_i, rd_ready_i, flush_i, freeze_i,
    output wr_ready_o, rd_data_o, rd_valid_o, data_o, win_valid_o,
           level_o, fl_full, fl_empty, fl_afull, fl_aempty, ovf_o
  );

  modport master (
    output wr_i, wr_valid_i, rd_ready_i, flush_i, freeze_i,
    input  wr_ready_o, rd_data_o, rd_valid_o, data_o, win_valid_o,
           level_o, fl_full, fl_empty, fl_afull, fl_aempty, ovf_o
  );
endinterface

// File: rtl/sync_window_fifo_n_m.sv
// Show-ahead FIFO of 2**ADDRESS words with registered flags, occupancy count,
// sticky overflow, and an M-word window of the newest writes that can be frozen.
module sync_window_fifo_n_m #(
  parameter int N       = 32,
  parameter int ADDRESS = 4,
  parameter int M       = 16,
  parameter int AFULL   = 12,
  parameter int AEMPTY  = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  sync_window_fifo_n_m_if.slave  io
);
  localparam int DEPTH = 1 << ADDRESS;
  localparam int LW    = ADDRESS + 1;
  localparam int CW    = $clog2(M + 1);

  localparam logic [LW-1:0] LVL_ONE   = LW'(1);
  localparam logic [LW-1:0] LVL_DEPTH = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_AF    = LW'(AFULL);
  localparam logic [LW-1:0] LVL_AE    = LW'(AEMPTY);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_M     = CW'(M);

  typedef enum logic [1:0] {OCC_EMPTY, OCC_PARTIAL, OCC_FULL} occ_e;

  logic [N-1:0]        mem_q [DEPTH];
  logic [LW-1:0]       wp_q, wp_d, rp_q, rp_d;
  logic [LW-1:0]       level_q, level_d;
  occ_e                occ_q, occ_d;
  logic                afull_q, afull_d, aempty_q, aempty_d;
  logic                ovf_q, ovf_d;
  logic [N-1:0]        rd_data_q, rd_data_d;
  logic [M-1:0][N-1:0] win_q, win_d;
  logic [CW-1:0]       win_cnt_q, win_cnt_d;
  logic                win_valid_q, win_valid_d;
  logic                wr_acc, rd_acc;

  assign wr_acc = io.wr_valid_i & (occ_q != OCC_FULL);
  assign rd_acc = io.rd_ready_i & (occ_q != OCC_EMPTY);

  always_comb begin
    wp_d        = wp_q;
    rp_d        = rp_q;
    level_d     = level_q;
    ovf_d       = ovf_q;
    rd_data_d   = rd_data_q;
    win_d       = win_q;
    win_cnt_d   = win_cnt_q;
    if (io.flush_i) begin
      wp_d      = '0;
      rp_d      = '0;
      level_d   = '0;
      rd_data_d = '0;
      win_d     = '0;
      win_cnt_d = '0;
    end else begin
      ovf_d = ovf_q | (io.wr_valid_i & (occ_q == OCC_FULL));
      if (wr_acc) wp_d = wp_q + LVL_ONE;
      if (rd_acc) rp_d = rp_q + LVL_ONE;
      case ({wr_acc, rd_acc})
        2'b10:   level_d = level_q + LVL_ONE;
        2'b01:   level_d = level_q - LVL_ONE;
        default: level_d = level_q;
      endcase
      // New head is the word being written only when it will be the sole entry.
      if (wr_acc && (rp_d == wp_q)) rd_data_d = io.wr_i;
      else                          rd_data_d = mem_q[rp_d[ADDRESS-1:0]];
      if (wr_acc && !io.freeze_i) begin
        for (int k = 0; k < M - 1; k++) win_d[k] = win_q[k+1];
        win_d[M-1] = io.wr_i;
        if (win_cnt_q != CNT_M) win_cnt_d = win_cnt_q + CNT_ONE;
      end
    end
    win_valid_d = (win_cnt_d == CNT_M);
    afull_d     = (level_d >= LVL_AF);
    aempty_d    = (level_d <= LVL_AE);
    if (level_d == '0)            occ_d = OCC_EMPTY;
    else if (level_d == LVL_DEPTH) occ_d = OCC_FULL;
    else                          occ_d = OCC_PARTIAL;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wp_q        <= '0;
      rp_q        <= '0;
      level_q     <= '0;
      occ_q       <= OCC_EMPTY;
      afull_q     <= 1'b0;
      aempty_q    <= 1'b1;
      ovf_q       <= 1'b0;
      rd_data_q   <= '0;
      win_q       <= '0;
      win_cnt_q   <= '0;
      win_valid_q <= 1'b0;
    end else begin
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      level_q     <= level_d;
      occ_q       <= occ_d;
      afull_q     <= afull_d;
      aempty_q    <= aempty_d;
      ovf_q       <= ovf_d;
      rd_data_q   <= rd_data_d;
      win_q       <= win_d;
      win_cnt_q   <= win_cnt_d;
      win_valid_q <= win_valid_d;
    end
  end

  // Storage is not reset; pointers alone define which words are live.
  always_ff @(posedge clk_i) begin
    if (!rst_i && !io.flush_i && wr_acc) mem_q[wp_q[ADDRESS-1:0]] <= io.wr_i;
  end

  assign io.wr_ready_o  = (occ_q != OCC_FULL);
  assign io.rd_valid_o  = (occ_q != OCC_EMPTY);
  assign io.fl_full     = (occ_q == OCC_FULL);
  assign io.fl_empty    = (occ_q == OCC_EMPTY);
  assign io.fl_afull    = afull_q;
  assign io.fl_aempty   = aempty_q;
  assign io.level_o     = level_q;
  assign io.ovf_o       = ovf_q;
  assign io.rd_data_o   = rd_data_q;
  assign io.data_o      = win_q;
  assign io.win_valid_o = win_valid_q;
endmodule

// File: tb/tb_sync_window_fifo_n_m.sv
// Scoreboard bench: the driver keeps a queue-based reference model and posts expectations,
// and a negedge monitor compares the expectations with the DUT outputs.
module tb_sync_window_fifo_n_m;
  localparam int N = 32, ADDRESS = 4, M = 16, AFULL = 12, AEMPTY = 2;
  localparam int DEPTH = 1 << ADDRESS;

  typedef struct {
    int                  level;
    bit                  full, empty, afull, aempty, wrdy, rvld, wvld, ovf;
    logic [M-1:0][N-1:0] win;
  } exp_t;

  logic clk = 0, rst = 1;
  always #5 clk = ~clk;

  sync_window_fifo_n_m_if #(.N(N), .ADDRESS(ADDRESS), .M(M)) io ();
  sync_window_fifo_n_m #(.N(N), .ADDRESS(ADDRESS), .M(M), .AFULL(AFULL), .AEMPTY(AEMPTY))
    dut (.clk_i(clk), .rst_i(rst), .io(io));

  int tests = 0, fails = 0;
  int m_level = 0, m_wcnt = 0;
  bit m_ovf = 0;
  logic [N-1:0] hist[$];
  logic [N-1:0] exp_rd[$];
  exp_t exp_st[$];

  task automatic chk(string nm, logic [M*N-1:0] act, logic [M*N-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t model_now();
    exp_t e;
    e.level  = m_level;
    e.full   = (m_level == DEPTH);
    e.empty  = (m_level == 0);
    e.afull  = (m_level >= AFULL);
    e.aempty = (m_level <= AEMPTY);
    e.wrdy   = !e.full;
    e.rvld   = !e.empty;
    e.wvld   = (m_wcnt >= M);
    e.ovf    = m_ovf;
    e.win    = '0;
    for (int i = 0; i < hist.size(); i++) e.win[M-1-i] = hist[hist.size()-1-i];
    return e;
  endfunction

  // One clock of stimulus; the model advances as the DUT will on the coming edge.
  task automatic step(bit rs, bit wv, logic [N-1:0] wd, bit rr, bit fl, bit fz);
    bit wa, ra;
    @(posedge clk); #1;
    exp_st.push_back(model_now());
    rst = rs; io.wr_valid_i = wv; io.wr_i = wd; io.rd_ready_i = rr;
    io.flush_i = fl; io.freeze_i = fz;
    if (rs || fl) begin
      if (rs) m_ovf = 0;
      m_level = 0; m_wcnt = 0; hist.delete(); exp_rd.delete();
    end else begin
      wa = wv && (m_level < DEPTH);
      ra = rr && (m_level > 0);
      if (wv && m_level == DEPTH) m_ovf = 1;
      m_level = m_level + int'(wa) - int'(ra);
      if (wa) exp_rd.push_back(wd);
      if (wa && !fz) begin
        hist.push_back(wd);
        if (hist.size() > M) void'(hist.pop_front());
        if (m_wcnt < M) m_wcnt++;
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_st.size() > 0) begin
      e = exp_st.pop_front();
      chk("level",     io.level_o,     e.level);
      chk("fl_full",   io.fl_full,     e.full);
      chk("fl_empty",  io.fl_empty,    e.empty);
      chk("fl_afull",  io.fl_afull,    e.afull);
      chk("fl_aempty", io.fl_aempty,   e.aempty);
      chk("wr_ready",  io.wr_ready_o,  e.wrdy);
      chk("rd_valid",  io.rd_valid_o,  e.rvld);
      chk("win_valid", io.win_valid_o, e.wvld);
      chk("ovf",       io.ovf_o,       e.ovf);
      chk("window",    io.data_o,      e.win);
    end
    if (!rst && !io.flush_i && io.rd_valid_o && io.rd_ready_i) begin
      if (exp_rd.size() == 0) begin
        tests++; fails++;
        $display("FAIL rd_pop: got word %0h expected no pop", io.rd_data_o);
      end else chk("rd_data", io.rd_data_o, exp_rd.pop_front());
    end
  end

  initial begin
    int wpct, rpct;
    bit wv, rr, fl, fz, rs;
    io.wr_valid_i = 0; io.wr_i = '0; io.rd_ready_i = 0; io.flush_i = 0; io.freeze_i = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("reset rd_data", io.rd_data_o, '0);
    chk("reset level",   io.level_o, '0);
    chk("reset empty",   io.fl_empty, 1'b1);

    step(0, 1, 'h11, 0, 0, 0);
    step(0, 1, 'h22, 0, 0, 0);
    step(0, 1, 'h33, 0, 0, 0);
    step(0, 0, '0, 0, 0, 0);
    for (int i = 0; i < 14; i++) step(0, 1, N'(32'h100 + i), 0, 0, 0);
    step(0, 1, 'hdead0010, 0, 0, 0);
    step(0, 1, 'hbeef, 1, 0, 0);
    step(0, 0, '0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, '0, 1, 0, 0);
    step(0, 0, '0, 0, 1, 0);
    step(0, 0, '0, 0, 0, 0);
    for (int i = 1; i <= 20; i++) step(0, 1, N'(i), (i > 10), 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, N'(32'h200 + i), 0, 0, 1);
    step(0, 1, 'h300, 0, 0, 0);
    step(0, 0, '0, 0, 0, 0);
    step(1, 0, '0, 0, 0, 0);
    step(0, 0, '0, 1, 0, 0);

    for (int p = 0; p < 16; p++) begin
      case (p % 4)
        0: begin wpct = 90; rpct = 10; end
        1: begin wpct = 10; rpct = 90; end
        2: begin wpct = 60; rpct = 60; end
        default: begin wpct = 80; rpct = 40; end
      endcase
      for (int c = 0; c < 100; c++) begin
        wv = ($urandom_range(0, 99) < wpct);
        rr = ($urandom_range(0, 99) < rpct);
        fl = ($urandom_range(0, 79) == 0);
        fz = (p % 4 == 3) ? bit'($urandom_range(0, 1)) : ($urandom_range(0, 9) == 0);
        rs = (p == 9 && c == 50);
        if (fl || rs) wv = 0;
        step(rs, wv, N'($urandom), rr, fl, fz);
      end
    end
    step(0, 0, '0, 0, 0, 0);
    step(0, 0, '0, 0, 0, 0);
    @(negedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
